// File: rtl/vlc_len_pkg.sv
// Shared types and length tables for the VLC code-length lookup path.
// lookup_len returns {illegal, len}; an illegal lookup always reports length 0.
package vlc_len_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       illegal;
        logic [3:0] len;
    } lut_res_t;

    localparam logic [1:0] TBL_VLC0 = 2'd0;
    localparam logic [1:0] TBL_VLC1 = 2'd1;

    // Entry 15 sits leftmost; T1 entry 15 is never read because that index is illegal.
    localparam logic [15:0][3:0] T0_LEN = {
        4'd9, 4'd9, 4'd9, 4'd8, 4'd8, 4'd7, 4'd7, 4'd6,
        4'd6, 4'd5, 4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd1
    };
    localparam logic [15:0][3:0] T1_LEN = {
        4'd0, 4'd6, 4'd6, 4'd6, 4'd6, 4'd5, 4'd5, 4'd4,
        4'd4, 4'd4, 4'd4, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3
    };

    function automatic lut_res_t lookup_len(input logic [1:0] tbl, input logic [3:0] idx);
        lut_res_t res;
        res = '{illegal: 1'b1, len: 4'd0};
        unique case (tbl)
            TBL_VLC0: res = '{illegal: 1'b0, len: T0_LEN[idx]};
            TBL_VLC1: begin
                if (idx == 4'd15) res = '{illegal: 1'b1, len: 4'd0};
                else              res = '{illegal: 1'b0, len: T1_LEN[idx]};
            end
            default:  res = '{illegal: 1'b1, len: 4'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vlc_len_lut.sv
// Combinational code-length lookup; shared with the single-symbol path.
// Indices wider than the 16 defined entries are illegal when any upper bit is set.
module vlc_len_lut
    import vlc_len_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int LEN_W = 4
) (
    input  logic [1:0]       i_tbl_sel,
    input  logic [IDX_W-1:0] i_sym_idx,
    output logic [LEN_W-1:0] o_sym_len,
    output logic             o_illegal
);

    logic [3:0] w_idx4;
    logic       w_hi_bad;
    lut_res_t   w_res;

    generate
        if (IDX_W > 4) begin : g_wide_idx
            assign w_idx4   = i_sym_idx[3:0];
            assign w_hi_bad = |i_sym_idx[IDX_W-1:4];
        end else begin : g_narrow_idx
            assign w_idx4   = 4'(i_sym_idx);
            assign w_hi_bad = 1'b0;
        end
    endgenerate

    assign w_res     = lookup_len(i_tbl_sel, w_idx4);
    assign o_illegal = w_res.illegal | w_hi_bad;
    assign o_sym_len = w_hi_bad ? '0 : LEN_W'(w_res.len);

endmodule

// File: rtl/vlc_len_accum.sv
// Burst VLC length decoder: per-symbol lengths with one cycle of latency,
// a saturating burst total and a sticky per-burst error.
module vlc_len_accum
    import vlc_len_pkg::*;
#(
    parameter int IDX_W    = 4,
    parameter int LEN_W    = 4,
    parameter int MAX_SYMS = 16,
    parameter int CNT_W    = $clog2(MAX_SYMS + 1),
    parameter int SUM_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       tbl_sel,
    input  logic [CNT_W-1:0] num_syms,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [IDX_W-1:0] sym_idx,
    output logic             len_valid,
    output logic [LEN_W-1:0] sym_len,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] total_len,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_tbl;
    logic [CNT_W-1:0] r_remaining;
    logic [SUM_W-1:0] r_total;
    logic             r_err;
    logic             r_len_valid;
    logic [LEN_W-1:0] r_sym_len;
    logic             r_busy;
    logic             r_done;

    logic             w_hs;
    logic             w_accept_start;
    logic [CNT_W-1:0] w_num_clamped;
    logic [LEN_W-1:0] w_lut_len;
    logic             w_lut_illegal;
    logic [SUM_W:0]   w_sum_ext;
    logic             w_sat;

    assign sym_ready      = (r_state == ST_RUN);
    assign w_hs           = sym_valid & sym_ready;
    assign w_accept_start = start & (r_state == ST_IDLE);
    assign w_num_clamped  = (num_syms > CNT_W'(MAX_SYMS)) ? CNT_W'(MAX_SYMS) : num_syms;

    vlc_len_lut #(
        .IDX_W (IDX_W),
        .LEN_W (LEN_W)
    ) u_lut (
        .i_tbl_sel (r_tbl),
        .i_sym_idx (sym_idx),
        .o_sym_len (w_lut_len),
        .o_illegal (w_lut_illegal)
    );

    // Extra carry bit detects overflow of the running total.
    assign w_sum_ext = {1'b0, r_total} + (SUM_W + 1)'(w_lut_len);
    assign w_sat     = w_sum_ext[SUM_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = (w_num_clamped == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_hs && (r_remaining == CNT_W'(1))) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tbl       <= TBL_VLC0;
            r_remaining <= '0;
            r_total     <= '0;
            r_err       <= 1'b0;
            r_len_valid <= 1'b0;
            r_sym_len   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_len_valid <= w_hs;
            r_done      <= (w_state_next == ST_DONE);
            r_busy      <= (w_state_next != ST_IDLE);
            if (w_accept_start) begin
                r_tbl       <= tbl_sel;
                r_remaining <= w_num_clamped;
                r_total     <= '0;
                r_err       <= (tbl_sel > TBL_VLC1);
            end
            if (w_hs) begin
                r_sym_len   <= w_lut_len;
                r_remaining <= r_remaining - CNT_W'(1);
                r_total     <= w_sat ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
                if (w_lut_illegal || w_sat) r_err <= 1'b1;
            end
        end
    end

    assign len_valid = r_len_valid;
    assign sym_len   = r_sym_len;
    assign busy      = r_busy;
    assign done      = r_done;
    assign total_len = r_total;
    assign err       = r_err;

endmodule

// File: tb/tb_vlc_len_accum.sv
// Directed bench for vlc_len_accum: one task per scenario, a second instance
// with a 6-bit total exercises saturation on the shared stimulus.
module tb_vlc_len_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] tbl_sel = 2'd0;
    logic [4:0] num_syms = 5'd0;
    logic       sym_valid = 1'b0;
    logic [3:0] sym_idx = 4'd0;

    wire        sym_ready, len_valid, busy, done, err;
    wire [3:0]  sym_len;
    wire [9:0]  total_len;
    wire        t6_sym_ready, t6_len_valid, t6_busy, t6_done, t6_err;
    wire [3:0]  t6_sym_len;
    wire [5:0]  t6_total;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_lbl = 0;
    int start_lbl = 0;
    int lv_cnt = 0;
    logic [3:0] cap_len[$];
    logic [3:0] stim_idx[16];
    int         stim_gap[16];

    vlc_len_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tbl_sel(tbl_sel), .num_syms(num_syms),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_idx(sym_idx),
        .len_valid(len_valid), .sym_len(sym_len), .busy(busy), .done(done),
        .total_len(total_len), .err(err)
    );

    vlc_len_accum #(.SUM_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start), .tbl_sel(tbl_sel), .num_syms(num_syms),
        .sym_valid(sym_valid), .sym_ready(t6_sym_ready), .sym_idx(sym_idx),
        .len_valid(t6_len_valid), .sym_len(t6_sym_len), .busy(t6_busy), .done(t6_done),
        .total_len(t6_total), .err(t6_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (len_valid) begin
            cap_len.push_back(sym_len);
            lv_cnt <= lv_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_lbl <= cyc;
        end
    end

    task automatic clear_capture();
        cap_len.delete();
        done_cnt = 0;
        lv_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            stim_idx[k] = 4'(k);
            stim_gap[k] = 0;
        end
    endtask

    // Called at a negedge; returns one negedge later with start released.
    task automatic do_start(input logic [1:0] tbl, input logic [4:0] n);
        start = 1'b1;
        tbl_sel = tbl;
        num_syms = n;
        start_lbl = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge just after the last handshake.
    task automatic drive_syms(input int nsym);
        int waited;
        for (int k = 0; k < nsym; k++) begin
            for (int g = 0; g < stim_gap[k]; g++) begin
                sym_valid = 1'b0;
                @(negedge clk);
            end
            sym_valid = 1'b1;
            sym_idx = stim_idx[k];
            waited = 0;
            while (!sym_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            vectors++;
            if (!sym_ready) begin
                $display("FAIL sym_ready_timeout: sym %0d got ready=%0b want 1", k, sym_ready);
                miscompares++;
            end
            @(negedge clk);
        end
        sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({sym_ready, len_valid, sym_len, busy, done, total_len, err} !== 19'd0) begin
            $display("FAIL reset_outputs: got rdy=%0b lv=%0b len=%0d busy=%0b done=%0b tot=%0d err=%0b want all 0",
                     sym_ready, len_valid, sym_len, busy, done, total_len, err);
            miscompares++;
        end
        vectors++;
        if ({t6_total, t6_err, t6_busy} !== 8'd0) begin
            $display("FAIL reset_dut6: got tot=%0d err=%0b busy=%0b want 0", t6_total, t6_err, t6_busy);
            miscompares++;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({sym_ready, busy, done, len_valid} !== 4'd0) begin
            $display("FAIL idle_after_reset: got rdy=%0b busy=%0b done=%0b lv=%0b want 0",
                     sym_ready, busy, done, len_valid);
            miscompares++;
        end
    endtask

    task automatic test_t0_full();
        int exp_len[16] = '{1, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 9, 9, 9};
        clear_capture();
        do_start(2'd0, 5'd16);
        drive_syms(16);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1 || sym_ready !== 1'b0) begin
            $display("FAIL t0_done_cycle: got done=%0b busy=%0b rdy=%0b want 1 1 0", done, busy, sym_ready);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (cap_len.size() != 16) begin
            $display("FAIL t0_len_count: got %0d want 16", cap_len.size());
            miscompares++;
        end
        for (int k = 0; k < 16 && k < cap_len.size(); k++) begin
            vectors++;
            if (cap_len[k] !== 4'(exp_len[k])) begin
                $display("FAIL t0_len[%0d]: got %0d want %0d", k, cap_len[k], exp_len[k]);
                miscompares++;
            end
        end
        vectors++;
        if (done_cnt != 1 || (done_lbl - start_lbl) != 17) begin
            $display("FAIL t0_done_latency: got cnt=%0d lat=%0d want cnt=1 lat=17", done_cnt, done_lbl - start_lbl);
            miscompares++;
        end
        vectors++;
        if (total_len !== 10'd94 || err !== 1'b0) begin
            $display("FAIL t0_total: got tot=%0d err=%0b want 94 0", total_len, err);
            miscompares++;
        end
        $display("t0_full: total=%0d err=%0b pulses=%0d", total_len, err, cap_len.size());
    endtask

    task automatic test_t1_gaps();
        int exp_len[15] = '{3, 3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 6, 6, 6, 6};
        int gaps[16] = '{0, 2, 0, 1, 3, 0, 0, 1, 0, 2, 0, 0, 1, 0, 4, 0};
        clear_capture();
        for (int k = 0; k < 16; k++) stim_gap[k] = gaps[k];
        do_start(2'd1, 5'd15);
        drive_syms(15);
        vectors++;
        if (sym_ready !== 1'b0) begin
            $display("FAIL t1_ready_drop: got %0b want 0", sym_ready);
            miscompares++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (lv_cnt != 15) begin
            $display("FAIL t1_len_count: got %0d want 15", lv_cnt);
            miscompares++;
        end
        for (int k = 0; k < 15 && k < cap_len.size(); k++) begin
            vectors++;
            if (cap_len[k] !== 4'(exp_len[k])) begin
                $display("FAIL t1_len[%0d]: got %0d want %0d", k, cap_len[k], exp_len[k]);
                miscompares++;
            end
        end
        vectors++;
        if (total_len !== 10'd65 || err !== 1'b0 || done_cnt != 1) begin
            $display("FAIL t1_total: got tot=%0d err=%0b done=%0d want 65 0 1", total_len, err, done_cnt);
            miscompares++;
        end
        $display("t1_gaps: total=%0d err=%0b pulses=%0d", total_len, err, lv_cnt);
    endtask

    task automatic test_illegal_idx_and_zero();
        clear_capture();
        stim_idx[0] = 4'd0;
        stim_idx[1] = 4'd15;
        stim_idx[2] = 4'd14;
        do_start(2'd1, 5'd3);
        drive_syms(3);
        repeat (4) @(negedge clk);
        vectors++;
        if (cap_len.size() != 3 || cap_len[0] !== 4'd3 || cap_len[1] !== 4'd0 || cap_len[2] !== 4'd6) begin
            $display("FAIL illegal_idx_lens: got n=%0d want 3,0,6", cap_len.size());
            miscompares++;
        end
        vectors++;
        if (total_len !== 10'd9 || err !== 1'b1) begin
            $display("FAIL illegal_idx_total: got tot=%0d err=%0b want 9 1", total_len, err);
            miscompares++;
        end
        clear_capture();
        do_start(2'd0, 5'd0);
        vectors++;
        if (done !== 1'b1 || (cyc - start_lbl) != 1) begin
            $display("FAIL zero_done: got done=%0b lat=%0d want 1 1", done, cyc - start_lbl);
            miscompares++;
        end
        vectors++;
        if (total_len !== 10'd0 || err !== 1'b0) begin
            $display("FAIL zero_total: got tot=%0d err=%0b want 0 0", total_len, err);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || lv_cnt != 0) begin
            $display("FAIL zero_after: got done=%0b busy=%0b pulses=%0d want 0 0 0", done, busy, lv_cnt);
            miscompares++;
        end
        $display("illegal_idx_and_zero: total=%0d err=%0b", total_len, err);
    endtask

    task automatic test_bad_table();
        clear_capture();
        stim_idx[0] = 4'd1;
        stim_idx[1] = 4'd2;
        do_start(2'd3, 5'd2);
        vectors++;
        if (err !== 1'b1) begin
            $display("FAIL bad_tbl_err_now: got %0b want 1", err);
            miscompares++;
        end
        drive_syms(2);
        repeat (2) @(negedge clk);
        vectors++;
        if (cap_len.size() != 2 || cap_len[0] !== 4'd0 || cap_len[1] !== 4'd0) begin
            $display("FAIL bad_tbl_lens: got n=%0d want two zero lengths", cap_len.size());
            miscompares++;
        end
        vectors++;
        if (err !== 1'b1 || total_len !== 10'd0) begin
            $display("FAIL bad_tbl_hold: got err=%0b tot=%0d want 1 0", err, total_len);
            miscompares++;
        end
        $display("bad_table: err=%0b total=%0d", err, total_len);
    endtask

    task automatic test_saturation();
        clear_capture();
        do_start(2'd0, 5'd16);
        drive_syms(16);
        vectors++;
        if (t6_done !== 1'b1 || t6_busy !== 1'b1 || t6_sym_ready !== 1'b0 ||
            t6_len_valid !== 1'b1 || t6_sym_len !== 4'd9) begin
            $display("FAIL sat_done_cycle: got done=%0b busy=%0b rdy=%0b lv=%0b len=%0d want 1 1 0 1 9",
                     t6_done, t6_busy, t6_sym_ready, t6_len_valid, t6_sym_len);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (t6_total !== 6'd63 || t6_err !== 1'b1) begin
            $display("FAIL sat_total: got tot=%0d err=%0b want 63 1", t6_total, t6_err);
            miscompares++;
        end
        vectors++;
        if (total_len !== 10'd94 || err !== 1'b0) begin
            $display("FAIL sat_wide_ref: got tot=%0d err=%0b want 94 0", total_len, err);
            miscompares++;
        end
        $display("saturation: total6=%0d err6=%0b", t6_total, t6_err);
    endtask

    task automatic test_abort();
        clear_capture();
        do_start(2'd0, 5'd16);
        drive_syms(5);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({sym_ready, len_valid, sym_len, busy, done, total_len, err} !== 19'd0) begin
            $display("FAIL abort_async: got rdy=%0b lv=%0b len=%0d busy=%0b done=%0b tot=%0d err=%0b want all 0",
                     sym_ready, len_valid, sym_len, busy, done, total_len, err);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            $display("FAIL abort_no_done: got done_cnt=%0d busy=%0b want 0 0", done_cnt, busy);
            miscompares++;
        end
        $display("abort: done_cnt=%0d busy=%0b", done_cnt, busy);
    endtask

    task automatic test_start_ignored();
        clear_capture();
        stim_idx[0] = 4'd0;
        stim_idx[1] = 4'd5;
        stim_idx[2] = 4'd9;
        stim_idx[3] = 4'd11;
        do_start(2'd1, 5'd4);
        drive_syms(2);
        start = 1'b1;
        tbl_sel = 2'd0;
        num_syms = 5'd1;
        stim_idx[0] = 4'd9;
        stim_idx[1] = 4'd11;
        drive_syms(2);
        start = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (cap_len.size() != 4 || cap_len[0] !== 4'd3 || cap_len[1] !== 4'd4 ||
            cap_len[2] !== 4'd5 || cap_len[3] !== 4'd6) begin
            $display("FAIL start_ign_lens: got n=%0d want 3,4,5,6", cap_len.size());
            miscompares++;
        end
        vectors++;
        if (total_len !== 10'd18 || err !== 1'b0 || done_cnt != 1) begin
            $display("FAIL start_ign_total: got tot=%0d err=%0b done=%0d want 18 0 1", total_len, err, done_cnt);
            miscompares++;
        end
        $display("start_ignored: total=%0d done_cnt=%0d", total_len, done_cnt);
    endtask

    task automatic test_back_to_back();
        int first_done;
        clear_capture();
        stim_idx[0] = 4'd3;
        do_start(2'd0, 5'd1);
        drive_syms(1);
        first_done = cyc;
        @(negedge clk);
        stim_idx[0] = 4'd5;
        do_start(2'd0, 5'd1);
        drive_syms(1);
        vectors++;
        if (done !== 1'b1 || (cyc - first_done) != 3) begin
            $display("FAIL b2b_period: got done=%0b period=%0d want 1 3", done, cyc - first_done);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (cap_len.size() != 2 || cap_len[0] !== 4'd4 || cap_len[1] !== 4'd5 ||
            total_len !== 10'd5 || done_cnt != 2) begin
            $display("FAIL b2b_result: got n=%0d tot=%0d done=%0d want 4,5 tot 5 done 2",
                     cap_len.size(), total_len, done_cnt);
            miscompares++;
        end
        $display("back_to_back: total=%0d done_cnt=%0d", total_len, done_cnt);
    endtask

    initial begin
        test_reset();
        test_t0_full();
        test_t1_gaps();
        test_illegal_idx_and_zero();
        test_bad_table();
        test_saturation();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
